// File: rtl/d_mem_iface_if.sv
// Request/response bundle between the pipeline memory stage and the data-memory interface.
// master = pipeline side (drives requests), slave = memory interface (drives responses).
interface d_mem_iface_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) ();
  logic                    stall;
  logic                    read;
  logic                    write;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [ADDRESS_BITS-1:0] out_addr;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    valid;
  logic                    ready;
  logic                    report;

  modport master (
    output stall, read, write, address, in_data, report,
    input  out_addr, out_data, valid, ready
  );

  modport slave (
    input  stall, read, write, address, in_data, report,
    output out_addr, out_data, valid, ready
  );
endinterface

// File: rtl/d_mem_iface.sv
// Data-memory interface for the pipeline memory stage: word-addressed single-port
// synchronous RAM, one load or store per cycle, load response registered one cycle later.
module d_mem_iface #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int OFFSET_BITS  = 3,
  parameter int ADDRESS_BITS = 20
) (
  input logic           clock,
  input logic           reset,
  d_mem_iface_if.slave  bus
);

  localparam int DEPTH = 1 << ADDRESS_BITS;

  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic [ADDRESS_BITS-1:0] out_addr_r;
  logic                    valid_r;
  logic                    unused_s;

  // RAM write port; the array has no reset so it maps onto a plain memory macro
  always_ff @(posedge clock) begin
    if (bus.write && !bus.stall) begin
      mem_r[bus.address] <= bus.in_data;
    end
  end

  // Load response registers; the read samples the pre-write word (read-before-write)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data_r <= '0;
      out_addr_r <= '0;
      valid_r    <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.read) begin
        out_data_r <= mem_r[bus.address];
        out_addr_r <= bus.address;
        valid_r    <= 1'b1;
      end else begin
        valid_r    <= 1'b0;
      end
    end
  end

  assign bus.out_data = out_data_r;
  assign bus.out_addr = out_addr_r;
  assign bus.valid    = valid_r;
  // No busy state exists, so the interface is ready whenever reset is released
  assign bus.ready    = reset;

  // Report dump and cache-geometry parameters carry no hardware here
  assign unused_s = ^{1'b0, bus.report, (CORE != 0), (INDEX_BITS != 0), (OFFSET_BITS != 0)};

endmodule

// File: tb/tb_d_mem_iface.sv
// Randomized scoreboard bench for d_mem_iface: a per-cycle expectation is queued when a
// request is issued and a separate monitor pops and compares after each rising edge.
module tb_d_mem_iface;

  localparam int DW = 32;
  localparam int AW = 20;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_known;

  d_mem_iface_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dif ();

  d_mem_iface #(
    .CORE(0), .DATA_WIDTH(DW), .INDEX_BITS(6), .OFFSET_BITS(3), .ADDRESS_BITS(AW)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the reference model applies the request rules to a word array
  task automatic drive(input logic rd, input logic wr, input logic stl,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    @(negedge clk);
    dif.read    = rd;
    dif.write   = wr;
    dif.stall   = stl;
    dif.address = addr;
    dif.in_data = data;
    if (!stl) begin
      if (rd) begin
        m_valid = 1'b1;
        m_addr  = addr;
        m_known = ref_mem.exists(addr);
        m_data  = m_known ? ref_mem[addr] : '0;
      end else begin
        m_valid = 1'b0;
      end
      if (wr) ref_mem[addr] = data;
    end
    e.v = m_valid; e.a = m_addr; e.d = m_data; e.k = m_known;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the DUT response after every rising edge against the queued expectation
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("valid", {63'd0, dif.valid}, {63'd0, e.v});
        chk("out_addr", {44'd0, dif.out_addr}, {44'd0, e.a});
        chk("ready", {63'd0, dif.ready}, 64'd1);
        if (e.k) chk("out_data", {32'd0, dif.out_data}, {32'd0, e.d});
      end else if (dif.valid !== 1'b0) begin
        chk("spurious_valid", {63'd0, dif.valid}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    dif.read = 1'b0; dif.write = 1'b0; dif.stall = 1'b0;
    dif.address = '0; dif.in_data = '0; dif.report = 1'b0;
    rst_n = 1'b0;
    m_valid = 1'b0; m_addr = '0; m_data = '0; m_known = 1'b1;

    // Reset state and ready tracking reset
    #2;
    chk("rst_out_data", {32'd0, dif.out_data}, 64'd0);
    chk("rst_out_addr", {44'd0, dif.out_addr}, 64'd0);
    chk("rst_valid", {63'd0, dif.valid}, 64'd0);
    chk("rst_ready_low", {63'd0, dif.ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_high", {63'd0, dif.ready}, 64'd1);
    mon_en = 1'b1;

    // Store then load
    drive(1'b0, 1'b1, 1'b0, 20'h00010, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 1'b0, 20'h00010, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 20'h00000, 32'h0);

    // Stalled store must not land; outputs hold across stall cycles
    drive(1'b1, 1'b0, 1'b0, 20'h00010, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 20'h00010, 32'h00001234);
    drive(1'b0, 1'b1, 1'b1, 20'h00010, 32'h00001234);
    drive(1'b1, 1'b0, 1'b0, 20'h00010, 32'h0);

    // Back-to-back loads then idle
    drive(1'b0, 1'b1, 1'b0, 20'h00011, 32'h0000000B);
    drive(1'b0, 1'b1, 1'b0, 20'h00012, 32'h0000000A);
    drive(1'b1, 1'b0, 1'b0, 20'h00012, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 20'h00011, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 20'h00011, 32'h0);

    // Same-address read and write returns the old word
    drive(1'b0, 1'b1, 1'b0, 20'h00020, 32'h00000005);
    drive(1'b1, 1'b1, 1'b0, 20'h00020, 32'h00000009);
    drive(1'b1, 1'b0, 1'b0, 20'h00020, 32'h0);

    // Top address boundary
    drive(1'b0, 1'b1, 1'b0, 20'hFFFFF, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 1'b0, 20'hFFFFF, 32'h0BADBEEF);
    drive(1'b1, 1'b0, 1'b0, 20'hFFFFF, 32'h0);

    // Asynchronous reset while a load result is valid
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, dif.valid}, 64'd0);
    chk("async_rst_out_data", {32'd0, dif.out_data}, 64'd0);
    chk("async_rst_out_addr", {44'd0, dif.out_addr}, 64'd0);
    chk("async_rst_ready", {63'd0, dif.ready}, 64'd0);
    m_valid = 1'b0; m_addr = '0; m_data = '0; m_known = 1'b1;
    @(negedge clk);
    dif.read = 1'b0; dif.write = 1'b0; dif.stall = 1'b0;
    rst_n = 1'b1;

    // RAM survives reset
    drive(1'b1, 1'b0, 1'b0, 20'h00010, 32'h0);

    // Randomized traffic over a small address window and the top of the space
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = 20'hFFFF8 + 20'($urandom_range(0, 7));
      else                           a = 20'h00010 + 20'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), a, $urandom);
    end
    drive(1'b0, 1'b0, 1'b0, 20'h00000, 32'h0);

    @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
